// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_phy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic [1:0]    sync_r;
  logic          rxs_s;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          deliver_s;
  logic          ferr_s;

  assign rxs_s = sync_r[1];

  // Synchronize the asynchronous serial line; idle-high reset avoids a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_phy};
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
    end
  end

  // Next-state logic: start bit checked at half period, later bits one full period apart.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    deliver_s = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_s) begin
          cnt_s   = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_C) begin
          if (!rxs_s) begin
            cnt_s   = '0;
            idx_s   = 3'd0;
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == LAST_C) begin
          shift_s = {rxs_s, shift_r[7:1]};
          cnt_s   = '0;
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == LAST_C) begin
          if (rxs_s) begin
            deliver_s = 1'b1;
            state_s   = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = WAIT_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxs_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Holding register, handshake and status pulses; a full register drops the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_busy   <= (state_s != IDLE);
      frame_err <= ferr_s;
      overrun   <= 1'b0;
      if (deliver_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_phy = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // negedge monitor counters (written only by the monitor)
  int n_hs = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_busy = 0;
  int gap_run = 0, last_gap = 0, last_rise = -1;
  logic prev_v = 1'b0;
  logic [7:0] hs_log [0:63];

  // snapshots taken by the tests
  int s_hs, s_vcyc, s_ferr, s_ovr, s_busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_phy   (rx_phy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      hs_log[n_hs[5:0]] <= rx_data;
      n_hs <= n_hs + 1;
    end
    if (rx_valid) n_vcyc <= n_vcyc + 1;
    if (rx_valid && !prev_v) last_rise <= cyc;
    prev_v <= rx_valid;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (rx_busy) begin
      n_busy <= n_busy + 1;
      if (gap_run != 0) last_gap <= gap_run;
      gap_run <= 0;
    end else begin
      gap_run <= gap_run + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_hs = n_hs; s_vcyc = n_vcyc; s_ferr = n_ferr; s_ovr = n_ovr; s_busy = n_busy;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_phy = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_phy = b[i];
      wait_cyc(CPB);
    end
    rx_phy = stop_bit;
    wait_cyc(CPB);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got %h exp 000", {rx_data, rx_valid, rx_busy, frame_err, overrun});
    end
    checks++;
    rst_n = 1'b1;
    wait_cyc(10);
    if ({rx_valid, rx_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_idle got %b exp 00", {rx_valid, rx_busy});
    end
    checks++;
  endtask

  task automatic test_single_hold();
    int s;
    snap();
    rx_ready = 1'b0;
    s = cyc;
    send_frame(8'hA5, 1'b1);
    if (last_rise !== s + 155) begin
      errors++; $display("FAIL a5_latency got %0d exp %0d", last_rise - s, 155);
    end
    checks++;
    wait_cyc(20);
    if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL a5_hold got %h exp 1a5", {rx_valid, rx_data});
    end
    checks++;
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin
      errors++; $display("FAIL a5_accept got %h exp 0a5", {rx_valid, rx_data});
    end
    checks++;
    if ((n_ferr - s_ferr) !== 0 || (n_ovr - s_ovr) !== 0 || (n_hs - s_hs) !== 1) begin
      errors++; $display("FAIL a5_flags got ferr %0d ovr %0d hs %0d exp 0 0 1",
                         n_ferr - s_ferr, n_ovr - s_ovr, n_hs - s_hs);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    snap();
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(5);
    rx_ready = 1'b0;
    if ((n_hs - s_hs) !== 2 || (n_vcyc - s_vcyc) !== 2) begin
      errors++; $display("FAIL b2b_count got hs %0d vcyc %0d exp 2 2", n_hs - s_hs, n_vcyc - s_vcyc);
    end
    checks++;
    if (hs_log[6'(s_hs)] !== 8'h00 || hs_log[6'(s_hs + 1)] !== 8'hFF) begin
      errors++; $display("FAIL b2b_data got %h %h exp 00 ff", hs_log[6'(s_hs)], hs_log[6'(s_hs + 1)]);
    end
    checks++;
    // stop sampled mid-bit; next start reaches IDLE 8 cycles later
    if (last_gap !== 8) begin
      errors++; $display("FAIL b2b_busy_gap got %0d exp 8", last_gap);
    end
    checks++;
  endtask

  task automatic test_glitch();
    snap();
    rx_phy = 1'b0;
    wait_cyc(4);
    rx_phy = 1'b1;
    wait_cyc(40);
    if ((n_vcyc - s_vcyc) !== 0 || (n_ferr - s_ferr) !== 0) begin
      errors++; $display("FAIL glitch_flags got vcyc %0d ferr %0d exp 0 0", n_vcyc - s_vcyc, n_ferr - s_ferr);
    end
    checks++;
    if ((n_busy - s_busy) !== 8) begin
      errors++; $display("FAIL glitch_busy got %0d exp 8", n_busy - s_busy);
    end
    checks++;
  endtask

  task automatic test_frame_err();
    snap();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    wait_cyc(24);
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL ferr_busy_held got %b exp 1", rx_busy);
    end
    checks++;
    if ((n_ferr - s_ferr) !== 1 || (n_vcyc - s_vcyc) !== 0) begin
      errors++; $display("FAIL ferr_pulse got ferr %0d vcyc %0d exp 1 0", n_ferr - s_ferr, n_vcyc - s_vcyc);
    end
    checks++;
    rx_phy = 1'b1;
    wait_cyc(4);
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL ferr_busy_release got %b exp 0", rx_busy);
    end
    checks++;
    wait_cyc(10);
    send_frame(8'h3C, 1'b1);
    wait_cyc(5);
    rx_ready = 1'b0;
    if ((n_hs - s_hs) !== 1 || hs_log[6'(s_hs)] !== 8'h3C || (n_ferr - s_ferr) !== 1) begin
      errors++; $display("FAIL ferr_next got hs %0d data %h ferr %0d exp 1 3c 1",
                         n_hs - s_hs, hs_log[6'(s_hs)], n_ferr - s_ferr);
    end
    checks++;
  endtask

  task automatic test_overrun();
    snap();
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    wait_cyc(5);
    send_frame(8'h34, 1'b1);
    wait_cyc(5);
    if ({rx_valid, rx_data} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL ovr_keep got %h exp 112", {rx_valid, rx_data});
    end
    checks++;
    if ((n_ovr - s_ovr) !== 1 || (n_ferr - s_ferr) !== 0) begin
      errors++; $display("FAIL ovr_pulse got ovr %0d ferr %0d exp 1 0", n_ovr - s_ovr, n_ferr - s_ferr);
    end
    checks++;
    snap();
    fork
      send_frame(8'h34, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    wait_cyc(5);
    if ({rx_valid, rx_data} !== {1'b1, 8'h34} || (n_ovr - s_ovr) !== 0) begin
      errors++; $display("FAIL ovr_replace got %h ovr %0d exp 134 0", {rx_valid, rx_data}, n_ovr - s_ovr);
    end
    checks++;
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_drain got %b exp 0", rx_valid);
    end
    checks++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] pat;
    pat = 8'hC3;
    rx_ready = 1'b1;
    rx_phy = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_phy = pat[i];
      wait_cyc(CPB);
    end
    rx_phy = pat[3];
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs got %h exp 000", {rx_data, rx_valid, rx_busy, frame_err, overrun});
    end
    checks++;
    wait_cyc(3);
    rx_phy = 1'b1;
    wait_cyc(2);
    snap();
    rst_n = 1'b1;
    wait_cyc(30);
    if ((n_vcyc - s_vcyc) !== 0 || (n_ferr - s_ferr) !== 0 || (n_ovr - s_ovr) !== 0) begin
      errors++; $display("FAIL mid_reset_spurious got vcyc %0d ferr %0d ovr %0d exp 0 0 0",
                         n_vcyc - s_vcyc, n_ferr - s_ferr, n_ovr - s_ovr);
    end
    checks++;
    send_frame(8'h81, 1'b1);
    wait_cyc(5);
    rx_ready = 1'b0;
    if ((n_hs - s_hs) !== 1 || hs_log[6'(s_hs)] !== 8'h81) begin
      errors++; $display("FAIL mid_reset_next got hs %0d data %h exp 1 81", n_hs - s_hs, hs_log[6'(s_hs)]);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
